// File: rtl/ram_program_loader.sv
// ram_program_loader
// Streams program bytes from a ready/valid source into a RAM through its
// manual-programming port, then optionally reads every programmed word back
// over the bus and compares it with a shadow copy of what was written.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle load request (honoured only when idle)
//   last_addr             final address to program, sampled on start
//   abort                 cancels a load in progress
//   rx_data/rx_valid      incoming program byte
//   rx_ready              byte accepted this cycle (only while waiting for a byte)
//   ram_manual_mode       RAM manual_mode
//   ram_manual_read       RAM manual_read, the write strobe
//   ram_write_to_bus      RAM write_to_bus, used by the verify pass
//   ram_address           RAM address
//   ram_program_switches  RAM write data
//   bus_in                bus value observed during verify
//   busy                  high whenever a load is in progress
//   done                  one-cycle completion pulse
//   verify_error          sticky read-back mismatch flag
//   error_addr            address of the first read-back mismatch
module ram_program_loader #(
    parameter int ADDR_W    = 4,
    parameter int DATA_W    = 8,
    parameter int VERIFY_EN = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              abort,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              ram_manual_mode,
    output logic              ram_manual_read,
    output logic              ram_write_to_bus,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_program_switches,
    input  logic [DATA_W-1:0] bus_in,
    output logic              busy,
    output logic              done,
    output logic              verify_error,
    output logic [ADDR_W-1:0] error_addr
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_BYTE,
        WRITE,
        VERIFY,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_addr_q, last_addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              verify_error_q, verify_error_d;
    logic [ADDR_W-1:0] error_addr_q, error_addr_d;
    logic              done_q, done_d;

    // Copy of every byte written, used as the reference during verify.
    logic [DATA_W-1:0] shadow_q [DEPTH];
    logic              shadow_we;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            last_addr_q    <= '0;
            wdata_q        <= '0;
            verify_error_q <= 1'b0;
            error_addr_q   <= '0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            last_addr_q    <= last_addr_d;
            wdata_q        <= wdata_d;
            verify_error_q <= verify_error_d;
            error_addr_q   <= error_addr_d;
            done_q         <= done_d;
        end
    end

    // Shadow storage carries no reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        if (shadow_we) begin
            shadow_q[addr_q] <= rx_data;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        last_addr_d    = last_addr_q;
        wdata_d        = wdata_q;
        verify_error_d = verify_error_q;
        error_addr_d   = error_addr_q;
        done_d         = 1'b0;
        shadow_we      = 1'b0;

        rx_ready             = 1'b0;
        ram_manual_mode      = 1'b0;
        ram_manual_read      = 1'b0;
        ram_write_to_bus     = 1'b0;
        ram_address          = '0;
        ram_program_switches = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    last_addr_d    = last_addr;
                    addr_d         = '0;
                    verify_error_d = 1'b0;
                    error_addr_d   = '0;
                    state_d        = WAIT_BYTE;
                end
            end

            WAIT_BYTE: begin
                rx_ready             = 1'b1;
                ram_manual_mode      = 1'b1;
                ram_address          = addr_q;
                ram_program_switches = wdata_q;
                // Abort wins over a simultaneous handshake; that byte is dropped.
                if (abort) begin
                    state_d = IDLE;
                end else if (rx_valid) begin
                    wdata_d   = rx_data;
                    shadow_we = 1'b1;
                    state_d   = WRITE;
                end
            end

            WRITE: begin
                ram_manual_mode      = 1'b1;
                ram_manual_read      = 1'b1;
                ram_address          = addr_q;
                ram_program_switches = wdata_q;
                if (abort) begin
                    state_d = IDLE;
                end else if (addr_q == last_addr_q) begin
                    addr_d  = '0;
                    state_d = (VERIFY_EN != 0) ? VERIFY : DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = WAIT_BYTE;
                end
            end

            VERIFY: begin
                ram_write_to_bus = 1'b1;
                ram_address      = addr_q;
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    // Only the first mismatch records its address.
                    if ((bus_in != shadow_q[addr_q]) && !verify_error_q) begin
                        verify_error_d = 1'b1;
                        error_addr_d   = addr_q;
                    end
                    if (addr_q == last_addr_q) begin
                        addr_d  = '0;
                        state_d = DONE;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end

            DONE: begin
                // done is registered, so the pulse appears on the cycle
                // after DONE, while the FSM is already back in IDLE.
                done_d  = !abort;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign verify_error = verify_error_q;
    assign error_addr   = error_addr_q;

endmodule

// File: tb/tb_ram_program_loader.sv
// Self-checking bench for ram_program_loader: a RAM model logs write strobes
// and serves bus reads (with optional corruption); each load is compared with
// the expected write sequence, verify pass and error result.
module tb_ram_program_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    always #5 clk = ~clk;

    // DUT with verify pass
    logic       start;
    logic [3:0] last_addr;
    logic       abort;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       mm, mr, wtb;
    logic [3:0] ram_address;
    logic [7:0] sw;
    logic [7:0] bus_in;
    logic       busy, done, verify_error;
    logic [3:0] error_addr;

    // DUT without verify pass
    logic       n_start;
    logic [3:0] n_last_addr;
    logic       n_abort;
    logic [7:0] n_rx_data;
    logic       n_rx_valid;
    logic       n_rx_ready;
    logic       n_mm, n_mr, n_wtb;
    logic [3:0] n_ram_address;
    logic [7:0] n_sw;
    logic [7:0] n_bus_in;
    logic       n_busy, n_done, n_verify_error;
    logic [3:0] n_error_addr;

    ram_program_loader #(.ADDR_W(4), .DATA_W(8), .VERIFY_EN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .last_addr(last_addr),
        .abort(abort), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .ram_manual_mode(mm), .ram_manual_read(mr), .ram_write_to_bus(wtb),
        .ram_address(ram_address), .ram_program_switches(sw), .bus_in(bus_in),
        .busy(busy), .done(done), .verify_error(verify_error), .error_addr(error_addr)
    );

    ram_program_loader #(.ADDR_W(4), .DATA_W(8), .VERIFY_EN(0)) u_dut_nv (
        .clk(clk), .rst_n(rst_n), .start(n_start), .last_addr(n_last_addr),
        .abort(n_abort), .rx_data(n_rx_data), .rx_valid(n_rx_valid), .rx_ready(n_rx_ready),
        .ram_manual_mode(n_mm), .ram_manual_read(n_mr), .ram_write_to_bus(n_wtb),
        .ram_address(n_ram_address), .ram_program_switches(n_sw), .bus_in(n_bus_in),
        .busy(n_busy), .done(n_done), .verify_error(n_verify_error), .error_addr(n_error_addr)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // RAM model: stores written words, returns them on the bus, corrupting
    // the addresses flagged in corrupt.
    logic [7:0]  mem [16];
    logic [15:0] corrupt;
    assign bus_in   = wtb ? (mem[ram_address] ^ (corrupt[ram_address] ? 8'hA5 : 8'h00)) : 8'h00;
    assign n_bus_in = 8'h00;

    logic [22:0] all_out;
    assign all_out = {rx_ready, mm, mr, wtb, ram_address, sw, busy, done, verify_error, error_addr};

    logic [3:0] wa_q [$];
    logic [7:0] wd_q [$];
    logic [3:0] ra_q [$];
    int done_cnt = 0;
    int cyc = 0;
    int n_wr_cnt = 0, n_wr_cyc = 0, n_done_cnt = 0, n_done_cyc = 0, n_wtb_cnt = 0;
    logic [7:0] n_wr_data = '0;
    logic [3:0] n_wr_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mr) begin
            wa_q.push_back(ram_address);
            wd_q.push_back(sw);
            mem[ram_address] <= sw;
        end
        if (wtb) ra_q.push_back(ram_address);
        if (done) done_cnt <= done_cnt + 1;
        if (mr || wtb) chk("strobe_exclusive", {31'd0, mr & wtb}, 32'd0);
        if (mm || mr || rx_ready) chk("manual_mode_states", {31'd0, mm}, {31'd0, rx_ready | mr});
        if (n_mr) begin
            n_wr_cnt  <= n_wr_cnt + 1;
            n_wr_cyc  <= cyc;
            n_wr_data <= n_sw;
            n_wr_addr <= n_ram_address;
        end
        if (n_done) begin
            n_done_cnt <= n_done_cnt + 1;
            n_done_cyc <= cyc;
        end
        if (n_wtb) n_wtb_cnt <= n_wtb_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [3:0] la);
        start     = 1'b1;
        last_addr = la;
        tick();
        start     = 1'b0;
        last_addr = 4'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok       = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_valid = 1'b1;
        rx_data  = b;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (!ok) chk("rx_handshake_timeout", 32'd0, 32'd1);
    endtask

    // Reference: byte i lands at address i, every address 0..la is read back
    // once, and the first corrupted address (if any) is the error address.
    task automatic run_load(input int la, input int gap_lo, input int gap_hi,
                            input logic [15:0] cmask, input bit seq);
        logic [7:0] b [16];
        int bw, br, bd;
        bit seen, exp_err;
        int exp_ea;
        bw = wa_q.size();
        br = ra_q.size();
        bd = done_cnt;
        corrupt = cmask;
        do_start(4'(la));
        for (int i = 0; i <= la; i++) begin
            b[i] = seq ? 8'(16 + i) : 8'($urandom);
            send_byte(b[i], int'($urandom_range(gap_hi, gap_lo)));
        end
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        tick();
        tick();
        chk("write_count", wa_q.size() - bw, la + 1);
        for (int i = 0; i <= la; i++) begin
            chk("write_addr", {28'd0, wa_q[bw + i]}, i);
            chk("write_data", {24'd0, wd_q[bw + i]}, {24'd0, b[i]});
        end
        chk("verify_count", ra_q.size() - br, la + 1);
        for (int i = 0; i <= la; i++) chk("verify_addr", {28'd0, ra_q[br + i]}, i);
        chk("done_pulses", done_cnt - bd, 1);
        exp_err = 1'b0;
        exp_ea  = 0;
        for (int i = 0; i <= la; i++) begin
            if (cmask[i] && !exp_err) begin
                exp_err = 1'b1;
                exp_ea  = i;
            end
        end
        chk("verify_error", {31'd0, verify_error}, {31'd0, exp_err});
        chk("error_addr", {28'd0, error_addr}, exp_ea);
        chk("busy_after_load", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bw, bd;
        bit ok;
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        rst_n = 1'b0; start = 1'b0; last_addr = '0; abort = 1'b0;
        rx_data = '0; rx_valid = 1'b0; corrupt = '0;
        n_start = 1'b0; n_last_addr = '0; n_abort = 1'b0; n_rx_data = '0; n_rx_valid = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_outputs", {9'd0, all_out}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_after_reset", {9'd0, all_out}, 32'd0);

        // Full RAM, bytes 0x10..0x1F, rx_valid held
        run_load(15, 0, 0, 16'h0000, 1'b1);
        // Back-pressure with 3-cycle gaps
        run_load(2, 3, 3, 16'h0000, 1'b0);
        // Corrupted read-back at addresses 1 and 3
        run_load(3, 0, 0, 16'h000A, 1'b0);

        // Randomized loads
        for (int t = 0; t < 6; t++) begin
            run_load(int'($urandom_range(15, 0)), 0, 2,
                     16'($urandom & $urandom & $urandom), 1'b0);
        end

        // Abort while waiting for the byte of address 5
        bw = wa_q.size();
        bd = done_cnt;
        do_start(4'd9);
        for (int i = 0; i < 5; i++) send_byte(8'(i * 3 + 1), 0);
        tick();
        chk("rx_ready_before_abort", {31'd0, rx_ready}, 32'd1);
        abort = 1'b1; rx_valid = 1'b1; rx_data = 8'hEE;
        tick();
        abort = 1'b0; rx_valid = 1'b0;
        chk("busy_after_abort", {31'd0, busy}, 32'd0);
        chk("rx_ready_after_abort", {31'd0, rx_ready}, 32'd0);
        repeat (6) tick();
        chk("writes_before_abort", wa_q.size() - bw, 5);
        chk("no_done_on_abort", done_cnt - bd, 0);
        run_load(6, 0, 1, 16'h0000, 1'b0);

        // Reset during a WRITE cycle
        bw = wa_q.size();
        do_start(4'd5);
        send_byte(8'h77, 0);
        chk("write_strobe_in_write", {31'd0, mr}, 32'd1);
        chk("write_data_in_write", {24'd0, sw}, 32'h77);
        #2 rst_n = 1'b0;
        #1 chk("outputs_async_reset", {9'd0, all_out}, 32'd0);
        repeat (3) @(negedge clk);
        chk("outputs_held_in_reset", {9'd0, all_out}, 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("writes_after_reset", wa_q.size() - bw, 0);
        chk("idle_after_release", {9'd0, all_out}, 32'd0);
        run_load(4, 0, 1, 16'h0010, 1'b0);

        // No verify pass, single byte at address 0
        n_start = 1'b1; n_last_addr = 4'd0;
        tick();
        n_start = 1'b0; n_last_addr = 4'd7;
        n_rx_valid = 1'b1; n_rx_data = 8'h5C;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (n_rx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        n_rx_valid = 1'b0;
        chk("nv_handshake", {31'd0, ok}, 32'd1);
        repeat (6) tick();
        chk("nv_write_count", n_wr_cnt, 1);
        chk("nv_write_data", {24'd0, n_wr_data}, 32'h5C);
        chk("nv_write_addr", {28'd0, n_wr_addr}, 32'd0);
        chk("nv_done_count", n_done_cnt, 1);
        chk("nv_done_latency", n_done_cyc - n_wr_cyc, 2);
        chk("nv_bus_reads", n_wtb_cnt, 0);
        chk("nv_busy_after", {31'd0, n_busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
